// File: rtl/sdram_responder.sv
// Device end of the SDRAM command/data interface: decodes controller commands,
// tracks one open row per bank and serves sequential bursts from an internal array.
module sdram_responder #(
  parameter int ROW_BITS = 4,
  parameter int COL_BITS = 4
) (
  input  logic        clk,
  input  logic        notRst,
  input  logic        CKE,
  input  logic        notCS,
  input  logic        notRAS,
  input  logic        notCAS,
  input  logic        notWE,
  input  logic [1:0]  BA,
  input  logic [11:0] A,
  input  logic        UDQM,
  input  logic        LDQM,
  inout  wire  [15:0] DQ,
  output logic        initDone,
  output logic        cmdErr,
  output logic [15:0] refreshCount
);
  localparam int ADDR_BITS = 2 + ROW_BITS + COL_BITS;
  localparam int DEPTH     = 1 << ADDR_BITS;

  typedef enum logic [2:0] {
    CMD_MRS = 3'b000, CMD_REF = 3'b001, CMD_PRE = 3'b010, CMD_ACT = 3'b011,
    CMD_WR  = 3'b100, CMD_RD  = 3'b101, CMD_BST = 3'b110, CMD_NOP = 3'b111
  } cmd_e;

  typedef struct packed {
    logic                active;
    logic [1:0]          bank;
    logic [ROW_BITS-1:0] row;
    logic [COL_BITS-1:0] col;
    logic [2:0]          idx;
    logic [2:0]          last;   // burst length minus one
    logic                ap;
  } burst_t;

  function automatic logic [COL_BITS-1:0] burst_col(input logic [COL_BITS-1:0] col,
                                                     input logic [2:0] k,
                                                     input logic [2:0] last);
    logic [COL_BITS-1:0] mask;
    mask = COL_BITS'(last);
    return (col & ~mask) | ((col + COL_BITS'(k)) & mask);
  endfunction

  function automatic logic [2:0] bl_mask(input logic [1:0] code);
    case (code)
      2'd0:    return 3'd0;
      2'd1:    return 3'd1;
      2'd2:    return 3'd3;
      default: return 3'd7;
    endcase
  endfunction

  logic                init_done_q, init_done_d;
  logic                cmd_err_q, cmd_err_d;
  logic [15:0]         refresh_count_q, refresh_count_d;
  logic [3:0]          bank_open_q, bank_open_d;
  logic [ROW_BITS-1:0] bank_row_q [4];
  logic [ROW_BITS-1:0] bank_row_d [4];
  logic                cl3_q, cl3_d;
  logic [1:0]          bl_code_q, bl_code_d;
  logic                single_wr_q, single_wr_d;
  burst_t              rd_q, rd_d, wr_q, wr_d;
  logic                rd_wait_q, rd_wait_d;
  logic [1:0]          dqm_q, dqm_d;
  logic [15:0]         dq_out_q, dq_out_d;
  logic [1:0]          oe_q, oe_d;

  logic [15:0]          mem [DEPTH];
  logic                 mem_we;
  logic [1:0]           mem_be;
  logic [ADDR_BITS-1:0] mem_waddr, rd_addr;
  logic [15:0]          mem_wdata, rd_word;

  cmd_e cmd;
  logic rw_ok, trunc;

  // Only some opcode bits carry meaning; fold the rest so none dangles.
  logic unused_a;
  assign unused_a = ^A;

  assign cmd     = notCS ? CMD_NOP : cmd_e'({notRAS, notCAS, notWE});
  assign rw_ok   = init_done_q && bank_open_q[BA];
  assign trunc   = (cmd == CMD_BST) || (((cmd == CMD_RD) || (cmd == CMD_WR)) && rw_ok);
  assign rd_addr = {rd_q.bank, rd_q.row, burst_col(rd_q.col, rd_q.idx, rd_q.last)};
  assign rd_word = mem[rd_addr];

  always_comb begin
    // NOTE: every value driven here gets a default first, so no path can infer a latch.
    init_done_d     = init_done_q;
    cmd_err_d       = 1'b0;
    refresh_count_d = refresh_count_q;
    bank_open_d     = bank_open_q;
    bank_row_d      = bank_row_q;
    cl3_d           = cl3_q;
    bl_code_d       = bl_code_q;
    single_wr_d     = single_wr_q;
    rd_d            = rd_q;
    wr_d            = wr_q;
    rd_wait_d       = rd_wait_q;
    dqm_d           = dqm_q;
    dq_out_d        = dq_out_q;
    oe_d            = oe_q;
    mem_we          = 1'b0;
    mem_be          = ~{UDQM, LDQM};
    mem_waddr       = '0;
    mem_wdata       = DQ;

    if (CKE) begin
      dqm_d = {UDQM, LDQM};
      oe_d  = 2'b00;
      if (rd_q.active && !trunc) begin
        if (rd_wait_q) begin
          rd_wait_d = 1'b0;
        end else begin
          oe_d     = ~dqm_q;
          dq_out_d = rd_word;
          rd_d.idx = rd_q.idx + 3'd1;
          if (rd_q.idx == rd_q.last) begin
            rd_d.active = 1'b0;
            if (rd_q.ap) bank_open_d[rd_q.bank] = 1'b0;
          end
        end
      end
      if (wr_q.active && !trunc) begin
        mem_we    = 1'b1;
        mem_waddr = {wr_q.bank, wr_q.row, burst_col(wr_q.col, wr_q.idx, wr_q.last)};
        wr_d.idx  = wr_q.idx + 3'd1;
        if (wr_q.idx == wr_q.last) begin
          wr_d.active = 1'b0;
          if (wr_q.ap) bank_open_d[wr_q.bank] = 1'b0;
        end
      end
      if (trunc) begin
        rd_d.active = 1'b0;
        wr_d.active = 1'b0;
      end

      case (cmd)
        CMD_MRS: begin
          if (rd_q.active || wr_q.active || !((A[6:4] == 3'd2 || A[6:4] == 3'd3) && !A[2])) begin
            cmd_err_d = 1'b1;
          end else begin
            cl3_d       = A[4];
            bl_code_d   = A[1:0];
            single_wr_d = A[9];
            init_done_d = 1'b1;
          end
        end
        CMD_REF: begin
          if (|bank_open_q) cmd_err_d = 1'b1;
          else refresh_count_d = refresh_count_q + 16'd1;
        end
        CMD_PRE: begin
          if (A[10]) bank_open_d = 4'b0000;
          else bank_open_d[BA] = 1'b0;
        end
        CMD_ACT: begin
          if (!init_done_q || bank_open_q[BA]) begin
            cmd_err_d = 1'b1;
          end else begin
            bank_open_d[BA] = 1'b1;
            bank_row_d[BA]  = A[ROW_BITS-1:0];
          end
        end
        CMD_WR: begin
          if (!rw_ok) begin
            cmd_err_d = 1'b1;
          end else begin
            mem_we    = 1'b1;
            mem_waddr = {BA, bank_row_q[BA], A[COL_BITS-1:0]};
            wr_d.bank = BA;
            wr_d.row  = bank_row_q[BA];
            wr_d.col  = A[COL_BITS-1:0];
            wr_d.idx  = 3'd1;
            wr_d.last = single_wr_q ? 3'd0 : bl_mask(bl_code_q);
            wr_d.ap   = A[10];
            if (wr_d.last == 3'd0) begin
              wr_d.active = 1'b0;
              if (A[10]) bank_open_d[BA] = 1'b0;
            end else begin
              wr_d.active = 1'b1;
            end
          end
        end
        CMD_RD: begin
          if (!rw_ok) begin
            cmd_err_d = 1'b1;
          end else begin
            rd_d.active = 1'b1;
            rd_d.bank   = BA;
            rd_d.row    = bank_row_q[BA];
            rd_d.col    = A[COL_BITS-1:0];
            rd_d.idx    = 3'd0;
            rd_d.last   = bl_mask(bl_code_q);
            rd_d.ap     = A[10];
            rd_wait_d   = cl3_q;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop sees pre-edge values.
  always_ff @(posedge clk or negedge notRst) begin
    if (!notRst) begin
      init_done_q     <= 1'b0;
      cmd_err_q       <= 1'b0;
      refresh_count_q <= '0;
      bank_open_q     <= '0;
      bank_row_q      <= '{default: '0};
      cl3_q           <= 1'b0;
      bl_code_q       <= 2'd0;
      single_wr_q     <= 1'b0;
      rd_q            <= '0;
      wr_q            <= '0;
      rd_wait_q       <= 1'b0;
      dqm_q           <= 2'b00;
      dq_out_q        <= '0;
      oe_q            <= 2'b00;
    end else begin
      init_done_q     <= init_done_d;
      cmd_err_q       <= cmd_err_d;
      refresh_count_q <= refresh_count_d;
      bank_open_q     <= bank_open_d;
      bank_row_q      <= bank_row_d;
      cl3_q           <= cl3_d;
      bl_code_q       <= bl_code_d;
      single_wr_q     <= single_wr_d;
      rd_q            <= rd_d;
      wr_q            <= wr_d;
      rd_wait_q       <= rd_wait_d;
      dqm_q           <= dqm_d;
      dq_out_q        <= dq_out_d;
      oe_q            <= oe_d;
    end
  end

  // NOTE: the array has no reset; contents survive notRst like a real device.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      if (mem_be[0]) mem[mem_waddr][7:0]  <= mem_wdata[7:0];
      if (mem_be[1]) mem[mem_waddr][15:8] <= mem_wdata[15:8];
    end
  end

  assign DQ[15:8]     = oe_q[1] ? dq_out_q[15:8] : 8'hzz;
  assign DQ[7:0]      = oe_q[0] ? dq_out_q[7:0]  : 8'hzz;
  assign initDone     = init_done_q;
  assign cmdErr       = cmd_err_q;
  assign refreshCount = refresh_count_q;
endmodule

// File: doc/sdram_responder.md
Name: sdram_responder

Overview:
- Synthesizable responder for the SDRAM command/data interface driven by our SDRAM controller, acting as the device end of that interface.
- Decodes MRS, ACTIVATE, READ, WRITE, PRECHARGE, REFRESH and NOP commands, tracks one open row per bank and stores data in an internal array.
- Returns read data after the programmed CAS latency.
- Used as the on-chip target for controller bring-up and as the device model in controller benches.

Parameters:
- ROW_BITS, 4, row address bits taken from A at ACTIVATE.
- COL_BITS, 4, column address bits taken from A at READ/WRITE; must be >= 3.
- Array depth is 4 banks x 2^ROW_BITS x 2^COL_BITS words of 16 bits.

Ports:
- clk  in  1  global clock; all sampling on posedge.
- notRst  in  1  asynchronous active-low reset.
- CKE  in  1  clock enable; when 0, the command is ignored and bursts freeze.
- notCS  in  1  chip select, active low.
- notRAS  in  1  row strobe, active low.
- notCAS  in  1  column strobe, active low.
- notWE  in  1  write enable, active low.
- BA  in  2  bank address.
- A  in  12  address/opcode bus.
- UDQM  in  1  upper byte mask.
- LDQM  in  1  lower byte mask.
- DQ  inout  16  data bus; Hi-Z unless driving read data.
- initDone  out  1  high once a valid MRS has been accepted.
- cmdErr  out  1  one-cycle pulse on an illegal command.
- refreshCount  out  16  REFRESH commands accepted; wraps at 16'hFFFF -> 0.

Behaviour:
- Reset (notRst=0, async):
  - initDone=0, cmdErr=0, refreshCount=0, DQ Hi-Z.
  - All banks closed; CL=2, BL=1, single-write=0.
  - Burst engines idle. Array contents are not reset.
- Command decode: a command is valid on a posedge with CKE=1 and notCS=0. {notRAS,notCAS,notWE}:
  - 000 MRS, 001 REFRESH, 010 PRECHARGE, 011 ACTIVATE
  - 100 WRITE, 101 READ, 110 BURST STOP, 111 NOP
  - notCS=1 is treated as NOP.
- MRS:
  - Accepted only when no burst is active; otherwise cmdErr.
  - CL from A[6:4]: only 2 or 3 are legal.
  - BL from A[2:0]: 000=1, 001=2, 010=4, 011=8.
  - single-write from A[9].
  - Any other CL or BL code: cmdErr, mode unchanged.
  - A valid MRS sets initDone=1.
- ACTIVATE: opens row A[ROW_BITS-1:0] in bank BA. cmdErr if the bank is already open or initDone=0.
- PRECHARGE: A[10]=1 closes all banks; A[10]=0 closes bank BA. Closing an already-closed bank is legal. Never an error.
- REFRESH: refreshCount+1. cmdErr if any bank is open (count still does not increment).
- READ/WRITE:
  - cmdErr and ignored if bank BA is closed or initDone=0.
  - Column is A[COL_BITS-1:0]; A[10]=1 means auto-precharge of BA when the burst completes.
  - A new READ/WRITE/BURST STOP truncates any burst in progress on the same edge.
- Burst addressing:
  - Sequential; word k uses column {col[high bits], (col[low b bits]+k) mod BL}, where b = log2(BL).
  - Wraps within the aligned BL block.
- Write burst:
  - Word 0 is captured from DQ on the WRITE edge; word k on edge +k.
  - Burst length is 1 when single-write=1.
  - UDQM/LDQM sampled on the same edge block the write of DQ[15:8]/DQ[7:0].
- Read burst:
  - READ sampled on edge n. Word k is driven from just after edge n+CL-1+k, so the controller samples it at edge n+CL+k.
  - DQ returns to Hi-Z after edge n+CL+BL-1.
  - DQM sampled at edge m masks (Hi-Z) the respective byte of the word sampled at edge m+2.
- Read-to-write turnaround: a WRITE during a read burst releases DQ on that edge. The write is captured normally.
- CKE=0 during a burst: the burst word counter holds; the DQ drive state holds.
- cmdErr is registered: it pulses high for exactly one cycle after the offending edge.

Test Plan:
1. Reset, then MRS A=12'h020 (CL=2, BL=1) -> initDone=1 next cycle, no cmdErr; MRS A=12'h070 -> cmdErr pulse, CL stays 2.
2. ACTIVATE BA=1 A=5, WRITE col 3 with DQ=16'hA55A, READ col 3 at edge n -> DQ=16'hA55A sampled at edge n+2, Hi-Z at n+3.
3. MRS CL=3 BL=4; WRITE col 6 with data 1,2,3,4; READ col 6 -> read words in order 1,2,3,4 from columns 6,7,4,5, first sampled at n+3.
4. READ to a closed bank -> cmdErr pulse, DQ stays Hi-Z; ACTIVATE an open bank -> cmdErr; REFRESH with a bank open -> cmdErr, refreshCount unchanged.
5. Write 16'hFFFF with LDQM=1 over stored 16'h1234 -> readback 16'hFF34; READ BL=4 with UDQM at n+1 -> word sampled at n+3 has upper byte Hi-Z.
6. Deassert notRst mid read burst -> DQ Hi-Z immediately, banks closed, initDone=0; a following READ -> cmdErr.
